// File: rtl/core_pkg.sv
// Shared core definitions: default widths, NOP encoding, fetch alignment and fetch-queue entry.
package core_pkg;

   localparam int XLEN = 32;
   localparam int ILEN = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;
   localparam int INST_ALIGN = 4;

   typedef struct packed {
      logic [ILEN-1:0] inst;
      logic [XLEN-1:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; flush and reset both empty it, flush wins over push/pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         pop_dat_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign empty_o   = (r_count == '0);
   assign full_o    = (r_count == CW'(DEPTH));
   assign w_push    = push_i & ~full_o;
   assign w_pop     = pop_i & ~empty_o;
   assign count_o   = r_count;
   assign pop_dat_o = r_mem[r_rd_ptr];

   always_ff @(posedge clk_i) begin
      if (!rst_n_i || flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   // Storage is not reset; pointers and count alone define validity.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && !flush_i && w_push) r_mem[r_wr_ptr] <= push_dat_i;
   end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch front end with a DEPTH-entry prefetch queue; redirect flushes and restarts.
// Define FETCH_PREFETCH_BYPASS_EN to present a response directly to decode when the queue is empty.
module fetch_prefetch #(
   parameter int               XLEN     = core_pkg::XLEN,
   parameter int               ILEN     = core_pkg::ILEN,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   output logic             im_req_o,
   output logic [XLEN-1:0]  im_addr_o,
   input  logic             im_busy_i,
   input  logic [ILEN-1:0]  im_dout_i,
   input  logic             redirect_i,
   input  logic [XLEN-1:0]  redirect_pc_i,
   output logic             inst_valid_o,
   output logic [ILEN-1:0]  inst_o,
   output logic [XLEN-1:0]  inst_pc_o,
   input  logic             inst_ready_i
);

   import core_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]      r_pc;
   logic [XLEN-1:0]      r_rsp_pc;
   logic                 r_inflight;

   logic [CW-1:0]        w_count;
   logic [CW:0]          w_credit_use;
   logic                 w_empty;
   logic                 w_unused_full;
   logic [1:0]           w_unused_rpc;
   logic                 w_accept;
   logic                 w_rsp_vld;
   logic                 w_push;
   logic                 w_pop;
   logic [ILEN-1:0]      w_head_inst;
   logic [XLEN-1:0]      w_head_pc;

   assign w_unused_rpc = redirect_pc_i[1:0];

   // Conservative credit: slots are reserved for queued entries plus the outstanding fetch.
   assign w_credit_use = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign im_req_o     = rst_n_i & ~redirect_i & (w_credit_use < (CW+1)'(DEPTH));
   assign im_addr_o    = r_pc;
   assign w_accept     = im_req_o & ~im_busy_i;
   assign w_rsp_vld    = r_inflight & ~redirect_i;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_pc       <= RESET_PC;
         r_rsp_pc   <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
         if (redirect_i) begin
            r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
         end else if (w_accept) begin
            r_pc     <= r_pc + XLEN'(INST_ALIGN);
            r_rsp_pc <= r_pc;
         end
      end
   end

`ifdef FETCH_PREFETCH_BYPASS_EN
   logic w_byp;
   assign w_byp        = w_empty & w_rsp_vld;
   assign inst_valid_o = (~w_empty | w_rsp_vld) & ~redirect_i;
   assign w_push       = w_rsp_vld & ~(w_byp & inst_ready_i);
   assign w_pop        = ~w_empty & inst_valid_o & inst_ready_i;

   always_comb begin
      inst_o    = '0;
      inst_pc_o = '0;
      if (inst_valid_o) begin
         inst_o    = w_empty ? im_dout_i : w_head_inst;
         inst_pc_o = w_empty ? r_rsp_pc  : w_head_pc;
      end
   end
`else
   assign inst_valid_o = ~w_empty & ~redirect_i;
   assign w_push       = w_rsp_vld;
   assign w_pop        = inst_valid_o & inst_ready_i;

   always_comb begin
      inst_o    = '0;
      inst_pc_o = '0;
      if (inst_valid_o) begin
         inst_o    = w_head_inst;
         inst_pc_o = w_head_pc;
      end
   end
`endif

   sync_fifo #(
      .WIDTH (ILEN + XLEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .push_i     (w_push),
      .push_dat_i ({im_dout_i, r_rsp_pc}),
      .pop_i      (w_pop),
      .flush_i    (redirect_i),
      .pop_dat_o  ({w_head_inst, w_head_pc}),
      .count_o    (w_count),
      .empty_o    (w_empty),
      .full_o     (w_unused_full)
   );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch (default build, RESET_PC = 0x100, DEPTH = 4).
module tb_fetch_prefetch;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        im_req_o;
   logic [31:0] im_addr_o;
   logic        im_busy_i;
   logic [31:0] im_dout_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i;

   int checks = 0;
   int errors = 0;
   int nreq;
   logic [31:0] mem_addr = 32'h0;

   always #5 clk_i = ~clk_i;

   // Instruction memory: word at address A reads as ~A, returned the cycle after acceptance.
   always @(posedge clk_i) begin
      if (im_req_o && !im_busy_i) mem_addr <= im_addr_o;
   end
   assign im_dout_i = ~mem_addr;

   fetch_prefetch #(
      .XLEN     (32),
      .ILEN     (32),
      .DEPTH    (4),
      .RESET_PC (32'h100)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .im_req_o      (im_req_o),
      .im_addr_o     (im_addr_o),
      .im_busy_i     (im_busy_i),
      .im_dout_i     (im_dout_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .inst_valid_o  (inst_valid_o),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_ready_i  (inst_ready_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      chk({tag, "_vld"}, {31'd0, inst_valid_o}, 32'd1);
      chk({tag, "_pc"}, inst_pc_o, pc);
      chk({tag, "_inst"}, inst_o, ~pc);
   endtask

   initial begin
      rst_n_i = 1'b0; im_busy_i = 1'b0; redirect_i = 1'b0;
      redirect_pc_i = 32'h0; inst_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i); #1;
      chk("rst_req",  {31'd0, im_req_o}, 32'd0);
      chk("rst_addr", im_addr_o, 32'h100);
      chk("rst_vld",  {31'd0, inst_valid_o}, 32'd0);
      chk("rst_inst", inst_o, 32'h0);
      chk("rst_pc",   inst_pc_o, 32'h0);

      // Reset release: sequential fetch, first instruction at cycle 2
      @(negedge clk_i); rst_n_i = 1'b1; #1;
      chk("t1_c0_req",  {31'd0, im_req_o}, 32'd1);
      chk("t1_c0_addr", im_addr_o, 32'h100);
      chk("t1_c0_vld",  {31'd0, inst_valid_o}, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk_i); #1;
         chk($sformatf("t1_c%0d_addr", k), im_addr_o, 32'h100 + 32'(4 * k));
         if (k == 1) chk("t1_c1_vld", {31'd0, inst_valid_o}, 32'd0);
         else        chk_head($sformatf("t1_c%0d", k), 32'h100 + 32'(4 * (k - 2)));
      end

      // Consumer stalled after a redirect to 0x400: queue fills with exactly 4 fetches
      @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h400; inst_ready_i = 1'b0; #1;
      chk("t2_rd_vld", {31'd0, inst_valid_o}, 32'd0);
      chk("t2_rd_req", {31'd0, im_req_o}, 32'd0);
      nreq = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i); redirect_i = 1'b0; #1;
         if (im_req_o && !im_busy_i) nreq++;
      end
      chk("t2_nreq", 32'(nreq), 32'd4);
      chk("t2_full_req", {31'd0, im_req_o}, 32'd0);
      for (int d = 0; d < 5; d++) begin
         @(negedge clk_i); inst_ready_i = 1'b1; #1;
         if (d == 0) chk("t2_d0_req", {31'd0, im_req_o}, 32'd0);
         chk_head($sformatf("t2_d%0d", d), 32'h400 + 32'(4 * d));
      end

      // Busy stall on the request to 0x108
      @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h100; #1;
      @(negedge clk_i); redirect_i = 1'b0; #1;
      chk("t3_e0_addr", im_addr_o, 32'h100);
      @(negedge clk_i); #1;
      chk("t3_e1_addr", im_addr_o, 32'h104);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk_i); im_busy_i = 1'b1; #1;
         chk($sformatf("t3_busy%0d_req", b), {31'd0, im_req_o}, 32'd1);
         chk($sformatf("t3_busy%0d_addr", b), im_addr_o, 32'h108);
         if (b == 0)      chk_head("t3_e2", 32'h100);
         else if (b == 1) chk_head("t3_e3", 32'h104);
         else             chk("t3_e4_vld", {31'd0, inst_valid_o}, 32'd0);
      end
      @(negedge clk_i); im_busy_i = 1'b0; #1;
      chk("t3_e5_addr", im_addr_o, 32'h108);
      chk("t3_e5_vld",  {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk_i); #1;
      chk("t3_e6_addr", im_addr_o, 32'h10C);
      chk("t3_e6_vld",  {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk_i); #1;
      chk_head("t3_e7", 32'h108);
      @(negedge clk_i); #1;
      chk_head("t3_e8", 32'h10C);

      // Redirect to 0x2003 with two queued entries and one response in flight
      @(negedge clk_i); inst_ready_i = 1'b0; #1;
      chk_head("t4_f0", 32'h110);
      chk("t4_f0_addr", im_addr_o, 32'h118);
      @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'h2003; inst_ready_i = 1'b1; #1;
      chk("t4_rd_vld",  {31'd0, inst_valid_o}, 32'd0);
      chk("t4_rd_inst", inst_o, 32'h0);
      chk("t4_rd_pc",   inst_pc_o, 32'h0);
      chk("t4_rd_req",  {31'd0, im_req_o}, 32'd0);
      @(negedge clk_i); redirect_i = 1'b0; #1;
      chk("t4_g0_addr", im_addr_o, 32'h2000);
      chk("t4_g0_vld",  {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk_i); #1;
      chk("t4_g1_addr", im_addr_o, 32'h2004);
      chk("t4_g1_vld",  {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk_i); #1;
      chk_head("t4_g2", 32'h2000);

      // Fetch PC wraps at the top of the address space
      @(negedge clk_i); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
      @(negedge clk_i); redirect_i = 1'b0; #1;
      chk("t5_i0_addr", im_addr_o, 32'hFFFF_FFFC);
      @(negedge clk_i); #1;
      chk("t5_i1_addr", im_addr_o, 32'h0);
      @(negedge clk_i); #1;
      chk_head("t5_i2", 32'hFFFF_FFFC);
      @(negedge clk_i); #1;
      chk_head("t5_i3", 32'h0);

      // Reset mid-stream with a full queue
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i); inst_ready_i = 1'b0; #1;
      end
      chk("t6_full_req", {31'd0, im_req_o}, 32'd0);
      chk("t6_full_vld", {31'd0, inst_valid_o}, 32'd1);
      @(negedge clk_i); rst_n_i = 1'b0; #1;
      chk("t6_rst_req", {31'd0, im_req_o}, 32'd0);
      @(negedge clk_i); #1;
      chk("t6_rst_vld",  {31'd0, inst_valid_o}, 32'd0);
      chk("t6_rst_addr", im_addr_o, 32'h100);
      chk("t6_rst_inst", inst_o, 32'h0);
      @(negedge clk_i); rst_n_i = 1'b1; inst_ready_i = 1'b1; #1;
      chk("t6_j0_req",  {31'd0, im_req_o}, 32'd1);
      chk("t6_j0_addr", im_addr_o, 32'h100);
      chk("t6_j0_vld",  {31'd0, inst_valid_o}, 32'd0);
      @(negedge clk_i); #1;
      chk("t6_j1_vld",  {31'd0, inst_valid_o}, 32'd0);
      chk("t6_j1_addr", im_addr_o, 32'h104);
      @(negedge clk_i); #1;
      chk_head("t6_j2", 32'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
- Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue.
- Sits between the PC/instruction-memory port and decode in the core.
- Issues sequential instruction fetches ahead of decode and absorbs instruction-memory busy stalls and decode back-pressure.
- Flushes and restarts on a control-flow redirect; replaces the single-register fetch stage.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- im_req_o  out  1  fetch request valid.
- im_addr_o  out  XLEN  fetch address; bits [1:0] always 0.
- im_busy_i  in  1  memory not accepting this cycle.
- im_dout_i  in  ILEN  instruction data; valid the cycle after an accepted request.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  XLEN  restart address; bits [1:0] ignored.
- inst_valid_o  out  1  queue head valid.
- inst_o  out  ILEN  head instruction.
- inst_pc_o  out  XLEN  head instruction PC.
- inst_ready_i  in  1  decode accepts head (pop = inst_valid_o & inst_ready_i).

Behaviour:
- Clock is clk_i. rst_n_i is synchronous and active-low: sampled only on the rising edge of clk_i.
- Reset values:
  - fetch PC = RESET_PC; queue empty; in-flight flag = 0.
  - im_req_o = 0 in the cycle(s) rst_n_i is low; im_addr_o = RESET_PC.
  - inst_valid_o = 0; inst_o = 0; inst_pc_o = 0.
- Reset mid-operation discards queue contents and any in-flight response.
- Issue rule: im_req_o = !redirect_i & (count + inflight < DEPTH).
  - Credit is conservative: a same-cycle pop does not free a slot for issue.
- Acceptance: im_req_o & !im_busy_i.
  - On acceptance: fetch PC += 4, wrapping modulo 2^XLEN; inflight = 1 for the next cycle; the accepted PC is stored.
- Busy stall: while im_busy_i = 1, im_req_o and im_addr_o hold stable; no state advances.
- Response: the cycle after acceptance, im_dout_i and the stored PC are written to the queue tail, unless the response is killed.
- Timing from reset release, no stalls, no bypass:
  - Cycle 0: im_req_o = 1, im_addr_o = RESET_PC.
  - Cycle 1: write.
  - Cycle 2: inst_valid_o = 1.
- Steady state: one instruction per cycle while the consumer is ready.
- Output gating:
  - inst_valid_o = !empty & !redirect_i.
  - inst_o and inst_pc_o are driven 0 whenever inst_valid_o = 0.
- Simultaneous write and pop: both occur; count unchanged.
  - A full queue never receives a write, which the issue rule guarantees.
- Redirect (redirect_i = 1):
  - Queue is flushed at the edge; any response arriving the next cycle is killed.
  - Fetch PC <= {redirect_pc_i[XLEN-1:2], 2'b00}; no issue in the redirect cycle.
  - A pop in the redirect cycle is ignored.
  - First fetch from the new PC is in the cycle after the redirect.
  - Back-to-back redirects: the last one wins.
- Redirect while im_busy_i = 1 overrides the held request; the unaccepted address is abandoned.
- Queue pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro FETCH_PREFETCH_BYPASS_EN.
- Defined: when the queue is empty and a non-killed response arrives, it is presented combinationally on inst_o/inst_pc_o with inst_valid_o = 1 in the same cycle.
  - If popped that cycle, it is not written to the queue.
  - First instruction appears in cycle 1 after reset release.
- Undefined: all responses pass through the queue; minimum fetch-to-decode latency is 2 cycles.

Decomposition:
- Shared package core_pkg:
  - XLEN/ILEN defaults.
  - INST_NOP = 32'h0000_0013.
  - Instruction alignment constant 4.
  - Typedef for the fetch-queue entry struct {inst, pc}.
- One sub-module, sync_fifo, parametrised by WIDTH and DEPTH, with push/pop/flush/count/empty/full.
  - Synchronous active-low reset; reused elsewhere in the core.

Test Plan:
1. Reset release with RESET_PC = 0x100, inst_ready_i = 1, no busy -> im_addr_o sequence 0x100, 0x104, 0x108…; inst_pc_o 0x100 valid at cycle 2 (cycle 1 with bypass); one instruction per cycle thereafter.
2. inst_ready_i = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests issued; im_req_o = 0 thereafter; queue full; on ready, 4 instructions drain in order with correct PCs.
3. im_busy_i = 1 for 3 cycles on the request to 0x108 -> im_addr_o holds 0x108 for all 3 cycles; no duplicate or missing instruction in the output stream.
4. redirect_i with redirect_pc_i = 0x2003 while 1 response is in flight and 2 entries are queued -> inst_valid_o = 0 that cycle; next request is 0x2000; the in-flight response is never output; the first output is PC 0x2000.
5. Fetch PC = 0xFFFF_FFFC (XLEN = 32) -> the next request wraps to 0x0000_0000.
6. rst_n_i asserted low mid-stream with a full queue -> on the following edge inst_valid_o = 0 and im_addr_o = RESET_PC; no stale instruction appears after release.
